// File: rtl/dshot_pkg.sv
// Shared DShot definitions used by the RX decoder (and the TX encoder).
//   DSHOT_FRAME_BITS : bits per frame (11 throttle + 1 telemetry + 4 CRC)
//   DSHOT_THR_W      : throttle field width
//   DSHOT_CRC_W      : CRC field width
//   rx_state_t       : receive FSM states
//   dshot_crc()      : 4-bit nibble-XOR CRC over the 12-bit payload,
//                      complemented for inverted (bidirectional) DShot
package dshot_pkg;

  localparam int DSHOT_FRAME_BITS = 16;
  localparam int DSHOT_THR_W      = 11;
  localparam int DSHOT_CRC_W      = 4;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_CHECK
  } rx_state_t;

  function automatic logic [DSHOT_CRC_W-1:0] dshot_crc(input logic [11:0] v,
                                                        input logic        inv);
    logic [11:0] x;
    x = v ^ (v >> 4) ^ (v >> 8);
    return x[DSHOT_CRC_W-1:0] ^ {DSHOT_CRC_W{inv}};
  endfunction

endpackage

// File: rtl/dshot_in_sync.sv
// DShot line input conditioning.
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : raw DShot pin, asynchronous to clk
//   lvl        : synchronized, polarity-normalized line level (1 = pulse)
//   rise, fall : 1-clk strobes, aligned with the cycle lvl changes
// Synchronizer flops reset to the idle pin level so that reset release
// never produces a spurious edge.
module dshot_in_sync #(
  parameter bit INVERTED = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic lvl_c;
  logic lvl_r;

  assign lvl_c = sync2 ^ INVERTED;

  // Strobes are registered alongside lvl_r so lvl, rise and fall all
  // describe the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= INVERTED;
      sync2 <= INVERTED;
      lvl_r <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      lvl_r <= lvl_c;
      rise  <= lvl_c & ~lvl_r;
      fall  <= ~lvl_c & lvl_r;
    end
  end

  assign lvl = lvl_r;

endmodule

// File: rtl/dshot_rx_decoder.sv
// DShot receive decoder: times each high pulse on the line, shifts in 16
// bits MSB first and checks the CRC.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   dshot_in    : raw DShot line
//   throttle    : throttle of last good frame
//   telem_req   : telemetry request bit of last good frame
//   frame_valid : 1-clk pulse, good frame latched
//   crc_err     : 1-clk pulse, 16 bits received with CRC mismatch
//   frame_err   : 1-clk pulse, glitch, stuck-high or short frame
module dshot_rx_decoder
  import dshot_pkg::*;
#(
  parameter int unsigned BIT_CLKS      = 100,
  parameter int unsigned THRESH_CLKS   = 50,
  parameter int unsigned MIN_HIGH_CLKS = 10,
  parameter int unsigned MAX_HIGH_CLKS = 90,
  parameter int unsigned IDLE_CLKS     = 200,
  parameter int unsigned INVERTED      = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dshot_in,
  output logic [DSHOT_THR_W-1:0] throttle,
  output logic                   telem_req,
  output logic                   frame_valid,
  output logic                   crc_err,
  output logic                   frame_err
);

  localparam int unsigned CW = $clog2(IDLE_CLKS + 1);
  localparam logic [CW-1:0] C_THR  = CW'(THRESH_CLKS);
  localparam logic [CW-1:0] C_MIN  = CW'(MIN_HIGH_CLKS);
  localparam logic [CW-1:0] C_MAX  = CW'(MAX_HIGH_CLKS);
  localparam logic [CW-1:0] C_IDLE = CW'(IDLE_CLKS);
  localparam logic [4:0]    LAST_BIT = 5'(DSHOT_FRAME_BITS - 1);

  if (!(MIN_HIGH_CLKS < THRESH_CLKS && THRESH_CLKS < MAX_HIGH_CLKS &&
        MAX_HIGH_CLKS < BIT_CLKS && BIT_CLKS < IDLE_CLKS)) begin : g_param_check
    $error("dshot_rx_decoder: inconsistent timing parameters");
  end

  logic lvl;
  logic rise;
  logic fall;

  dshot_in_sync #(
    .INVERTED (INVERTED != 0)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (dshot_in),
    .lvl   (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  rx_state_t                 state, state_n;
  logic [CW-1:0]             cnt, cnt_n, cnt_inc;
  logic [4:0]                bitcnt, bitcnt_n;
  logic [15:0]               sr, sr_n;
  logic [DSHOT_THR_W-1:0]    thr_n;
  logic                      tel_n;
  logic                      fv_n, ce_n, fe_n;

  assign cnt_inc = (cnt == C_IDLE) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_ARM;
      cnt         <= '0;
      bitcnt      <= '0;
      sr          <= '0;
      throttle    <= '0;
      telem_req   <= 1'b0;
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bitcnt      <= bitcnt_n;
      sr          <= sr_n;
      throttle    <= thr_n;
      telem_req   <= tel_n;
      frame_valid <= fv_n;
      crc_err     <= ce_n;
      frame_err   <= fe_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    sr_n     = sr;
    thr_n    = throttle;
    tel_n    = telem_req;
    fv_n     = 1'b0;
    ce_n     = 1'b0;
    fe_n     = 1'b0;

    unique case (state)
      ST_ARM: begin
        if (lvl) begin
          cnt_n = '0;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == C_IDLE) state_n = ST_IDLE;
        end
      end

      // A rise that landed during CHECK shows up here as lvl already high
      // with no strobe; that pulse has then been high for one extra clock.
      ST_IDLE: begin
        if (lvl) begin
          state_n  = ST_HIGH;
          cnt_n    = rise ? CW'(1) : CW'(2);
          bitcnt_n = '0;
          sr_n     = '0;
        end
      end

      ST_HIGH: begin
        if (fall) begin
          if (cnt < C_MIN) begin
            fe_n    = 1'b1;
            state_n = ST_ARM;
            cnt_n   = '0;
          end else begin
            sr_n     = {sr[14:0], cnt > C_THR};
            bitcnt_n = bitcnt + 5'd1;
            if (bitcnt == LAST_BIT) begin
              state_n = ST_CHECK;
            end else begin
              state_n = ST_LOW;
              cnt_n   = CW'(1);
            end
          end
        end else if (cnt >= C_MAX) begin
          // Next clock would exceed the maximum high time.
          fe_n    = 1'b1;
          state_n = ST_ARM;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      ST_LOW: begin
        if (rise) begin
          state_n = ST_HIGH;
          cnt_n   = CW'(1);
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == C_IDLE) begin
            fe_n    = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end

      ST_CHECK: begin
        state_n = ST_IDLE;
        if (dshot_crc(sr[15:4], INVERTED != 0) == sr[3:0]) begin
          fv_n  = 1'b1;
          thr_n = sr[15:5];
          tel_n = sr[4];
        end else begin
          ce_n = 1'b1;
        end
      end

      default: state_n = ST_ARM;
    endcase
  end

endmodule

// File: tb/tb_dshot_rx_decoder.sv
module tb_dshot_rx_decoder;

  localparam int MINH = 10;
  localparam int MAXH = 90;
  localparam int THR  = 50;
  localparam int GAPL = 300;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        line  = 1'b0;
  logic [10:0] thr0, thr1;
  logic        tel0, tel1, fv0, fv1, ce0, ce1, fe0, fe1;

  int cyc = 0;
  int n_fv[2], n_ce[2], n_fe[2], last_fv[2], last_ce[2], last_fe[2];
  int overlap = 0, unstable = 0;
  logic [10:0] p_thr0 = '0, p_thr1 = '0;
  logic        p_tel0 = 1'b0, p_tel1 = 1'b0;

  int checks = 0, errors = 0;
  int hi_w[16], lo_w[16];
  int fall_cyc = 0;
  bit armed = 0;
  int exp_thr[2], exp_tel[2], e_fv[2], e_ce[2], e_fe[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dshot_rx_decoder dut0 (
    .clk(clk), .rst_n(rst_n), .dshot_in(line),
    .throttle(thr0), .telem_req(tel0),
    .frame_valid(fv0), .crc_err(ce0), .frame_err(fe0)
  );

  dshot_rx_decoder #(.INVERTED(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .dshot_in(~line),
    .throttle(thr1), .telem_req(tel1),
    .frame_valid(fv1), .crc_err(ce1), .frame_err(fe1)
  );

  // Pulse bookkeeping, exclusivity and output stability, sampled mid-cycle.
  always @(negedge clk) begin
    if (fv0) begin n_fv[0]++; last_fv[0] = cyc; end
    if (ce0) begin n_ce[0]++; last_ce[0] = cyc; end
    if (fe0) begin n_fe[0]++; last_fe[0] = cyc; end
    if (fv1) begin n_fv[1]++; last_fv[1] = cyc; end
    if (ce1) begin n_ce[1]++; last_ce[1] = cyc; end
    if (fe1) begin n_fe[1]++; last_fe[1] = cyc; end
    if (int'(fv0) + int'(ce0) + int'(fe0) > 1) overlap++;
    if (int'(fv1) + int'(ce1) + int'(fe1) > 1) overlap++;
    if (rst_n && !fv0 && (thr0 != p_thr0 || tel0 != p_tel0)) unstable++;
    if (rst_n && !fv1 && (thr1 != p_thr1 || tel1 != p_tel1)) unstable++;
    p_thr0 = thr0; p_tel0 = tel0;
    p_thr1 = thr1; p_tel1 = tel1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic int crc_of(input int v, input int inv);
    int c;
    c = (v ^ (v >> 4) ^ (v >> 8)) & 15;
    return inv != 0 ? c ^ 15 : c;
  endfunction

  task automatic nominal(input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      hi_w[i] = w[15-i] ? 75 : 37;
      lo_w[i] = 100 - hi_w[i];
    end
  endtask

  task automatic randomize_widths(input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      hi_w[i] = w[15-i] ? int'($urandom_range(90, 51)) : int'($urandom_range(50, 10));
      lo_w[i] = int'($urandom_range(60, 10));
    end
  endtask

  // Reference: decode the pulse list by the protocol rules.
  task automatic predict(input int first, input int nb, input int gap);
    int w, n, c;
    bit err;
    for (int d = 0; d < 2; d++) begin
      e_fv[d] = 0; e_ce[d] = 0; e_fe[d] = 0;
    end
    if (!armed) begin
      if (gap >= GAPL) armed = 1;
      return;
    end
    w = 0; n = 0; err = 0;
    for (int i = 0; i < nb; i++) begin
      if (hi_w[first+i] < MINH || hi_w[first+i] > MAXH) begin
        err = 1;
        break;
      end
      w = (w << 1) | (hi_w[first+i] > THR ? 1 : 0);
      n++;
    end
    if (err) begin
      e_fe[0] = 1; e_fe[1] = 1;
      armed = (gap >= GAPL);
    end else if (n < 16) begin
      if (gap >= GAPL) begin e_fe[0] = 1; e_fe[1] = 1; end
    end else begin
      for (int d = 0; d < 2; d++) begin
        c = crc_of(w >> 4, d);
        if (c == (w & 15)) begin
          e_fv[d] = 1;
          exp_thr[d] = w >> 5;
          exp_tel[d] = (w >> 4) & 1;
        end else begin
          e_ce[d] = 1;
        end
      end
    end
  endtask

  task automatic send(input int first, input int nb, input int gap);
    for (int i = first; i < first + nb; i++) begin
      line = 1'b1;
      step(hi_w[i]);
      line = 1'b0;
      if (i == first + nb - 1) begin
        fall_cyc = cyc;
        step(gap);
      end else begin
        step(lo_w[i]);
      end
    end
  endtask

  task automatic run(input string tag, input int first, input int nb, input int gap);
    int b_fv[2], b_ce[2], b_fe[2];
    for (int d = 0; d < 2; d++) begin
      b_fv[d] = n_fv[d]; b_ce[d] = n_ce[d]; b_fe[d] = n_fe[d];
    end
    predict(first, nb, gap);
    send(first, nb, gap);
    chk($sformatf("%s_fv0", tag), n_fv[0] - b_fv[0], e_fv[0]);
    chk($sformatf("%s_ce0", tag), n_ce[0] - b_ce[0], e_ce[0]);
    chk($sformatf("%s_fe0", tag), n_fe[0] - b_fe[0], e_fe[0]);
    chk($sformatf("%s_fv1", tag), n_fv[1] - b_fv[1], e_fv[1]);
    chk($sformatf("%s_ce1", tag), n_ce[1] - b_ce[1], e_ce[1]);
    chk($sformatf("%s_fe1", tag), n_fe[1] - b_fe[1], e_fe[1]);
    chk($sformatf("%s_thr0", tag), int'(thr0), exp_thr[0]);
    chk($sformatf("%s_tel0", tag), int'(tel0), exp_tel[0]);
    chk($sformatf("%s_thr1", tag), int'(thr1), exp_thr[1]);
    chk($sformatf("%s_tel1", tag), int'(tel1), exp_tel[1]);
  endtask

  initial begin
    int kind, v, w, c, gap, pos;

    for (int d = 0; d < 2; d++) begin exp_thr[d] = 0; exp_tel[d] = 0; end
    step(3);
    chk("rst_thr0", int'(thr0), 0);
    chk("rst_tel0", int'(tel0), 0);
    chk("rst_pulses0", int'(fv0) + int'(ce0) + int'(fe0), 0);
    chk("rst_thr1", int'(thr1), 0);
    chk("rst_pulses1", int'(fv1) + int'(ce1) + int'(fe1), 0);
    rst_n = 1'b1;
    step(GAPL);
    armed = 1;

    // Good frame (1046, telem 0); inverted decoder sees a CRC mismatch.
    nominal(16'h82C6);
    run("good", 0, 16, 100);
    chk("lat_fv0", last_fv[0] - fall_cyc, 5);
    chk("lat_ce1", last_ce[1] - fall_cyc, 5);

    nominal(16'h82C7);
    run("badcrc", 0, 16, 100);

    nominal(16'h82C9);
    run("invgood", 0, 16, 100);

    // Short frame: 10 bits then idle line.
    nominal(16'h82C6);
    run("short", 0, 10, GAPL);
    chk("lat_fe0", last_fe[0] - fall_cyc, 203);
    chk("lat_fe1", last_fe[1] - fall_cyc, 203);

    nominal(16'h0011);
    run("thr0tel1", 0, 16, 100);

    // Glitch mid-frame, a frame too soon after it, then a clean frame.
    nominal(16'h82C6);
    hi_w[5] = 5;
    run("glitch", 0, 16, 60);
    nominal(16'h0011);
    run("ignored", 0, 16, GAPL);
    nominal(16'h82C6);
    run("rearmed", 0, 16, 100);

    // Pulse-width boundaries.
    nominal(16'h82C6);
    for (int i = 0; i < 16; i++) begin
      if (hi_w[i] > THR) hi_w[i] = (i % 2 == 0) ? 51 : 90;
      else               hi_w[i] = (i % 2 == 0) ? 10 : 50;
      lo_w[i] = 100 - hi_w[i];
    end
    run("edges", 0, 16, 100);
    nominal(16'h0011);
    hi_w[3] = MINH - 1;
    run("min_m1", 0, 16, GAPL);
    nominal(16'h0011);
    hi_w[3] = MAXH + 1;
    run("max_p1", 0, 16, GAPL);

    // Reset in the middle of a frame.
    nominal(16'h0011);
    run("part", 0, 7, 20);
    rst_n = 1'b0;
    step(3);
    chk("mid_rst_thr0", int'(thr0), 0);
    chk("mid_rst_tel0", int'(tel0), 0);
    chk("mid_rst_thr1", int'(thr1), 0);
    chk("mid_rst_tel1", int'(tel1), 0);
    rst_n = 1'b1;
    armed = 0;
    for (int d = 0; d < 2; d++) begin exp_thr[d] = 0; exp_tel[d] = 0; end
    run("post_rst", 7, 9, GAPL);
    nominal(16'h82C6);
    run("after_rst", 0, 16, 100);

    // Randomized frames and faults.
    for (int k = 0; k < 16; k++) begin
      kind = int'($urandom_range(0, 9));
      v = int'($urandom_range(4095, 0));
      case ($urandom_range(0, 2))
        0:       c = crc_of(v, 0);
        1:       c = crc_of(v, 1);
        default: c = int'($urandom_range(15, 0));
      endcase
      w = (v << 4) | c;
      randomize_widths(16'(w));
      gap = int'($urandom_range(120, 30));
      if (kind == 0) begin
        pos = int'($urandom_range(15, 0));
        hi_w[pos] = int'($urandom_range(MINH - 1, 3));
        run($sformatf("rnd%0d_glitch", k), 0, 16, GAPL);
      end else if (kind == 1) begin
        pos = int'($urandom_range(15, 0));
        hi_w[pos] = int'($urandom_range(MAXH + 5, MAXH + 1));
        run($sformatf("rnd%0d_stuck", k), 0, 16, GAPL);
      end else if (kind == 2) begin
        run($sformatf("rnd%0d_short", k), 0, int'($urandom_range(15, 1)), GAPL);
      end else begin
        run($sformatf("rnd%0d", k), 0, 16, gap);
      end
    end

    chk("pulse_overlap", overlap, 0);
    chk("output_stability", unstable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
